// File: rtl/escaner_pkg.sv
// Shared types and default timing for the display refresh scanner.
package escaner_pkg;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        BLANK = 2'd1,
        SHOW  = 2'd2
    } estado_t;

    localparam int DEFAULT_PRESCALE     = 100000;
    localparam int DEFAULT_BLANK_CYCLES = 1000;

endpackage

// File: rtl/selector_siguiente.sv
// Wrap-around search for the next enabled digit, starting at index+1.
// Passing index 3 yields the lowest set bit of the mask.
module selector_siguiente (
    input  logic [1:0] indice,
    input  logic [3:0] mask,
    output logic [1:0] siguiente,
    output logic       valido
);

    // Scan offsets 4 down to 1 so the closest set bit above the index wins.
    always_comb begin
        logic [1:0] cand;
        siguiente = indice;
        valido    = 1'b0;
        cand      = 2'd0;
        for (int k = 4; k >= 1; k--) begin
            cand = indice + 2'(k);
            if (mask[cand]) begin
                siguiente = cand;
                valido    = 1'b1;
            end
        end
    end

endmodule

// File: rtl/escaner_refresco.sv
// Multiplexed display scanner: each enabled digit gets a slot of PRESCALE
// cycles, the first BLANK_CYCLES of which keep all anodes off so the digit
// index only ever moves while the display is dark.
module escaner_refresco
    import escaner_pkg::*;
#(
    parameter int PRESCALE     = DEFAULT_PRESCALE,
    parameter int BLANK_CYCLES = DEFAULT_BLANK_CYCLES
) (
    input  logic       clk,
    input  logic       rst_n,
    input  logic       en,
    input  logic [3:0] digit_mask,
    output logic [1:0] refrescamiento,
    output logic       blank,
    output logic       slot_start
);

    localparam int CW = $clog2(PRESCALE);
    localparam logic [CW-1:0] LAST_BLANK = CW'(BLANK_CYCLES - 1);
    localparam logic [CW-1:0] LAST_SHOW  = CW'(PRESCALE - 1);

    estado_t       estado;
    logic [CW-1:0] cnt;
    logic [1:0]    sel_indice;
    logic [1:0]    sel_siguiente;
    logic          sel_valido;

    // From IDLE, search from index 3 so the lowest enabled digit is picked.
    assign sel_indice = (estado == IDLE) ? 2'd3 : refrescamiento;

    selector_siguiente u_selector (
        .indice    (sel_indice),
        .mask      (digit_mask),
        .siguiente (sel_siguiente),
        .valido    (sel_valido)
    );

    // Slot sequencer; the index moves on the same edge that raises blank.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            estado         <= IDLE;
            cnt            <= '0;
            refrescamiento <= 2'b00;
            blank          <= 1'b1;
            slot_start     <= 1'b0;
        end else if (!en) begin
            estado     <= IDLE;
            cnt        <= '0;
            blank      <= 1'b1;
            slot_start <= 1'b0;
        end else begin
            slot_start <= 1'b0;
            case (estado)
                IDLE: begin
                    cnt   <= '0;
                    blank <= 1'b1;
                    if (sel_valido) begin
                        estado         <= BLANK;
                        refrescamiento <= sel_siguiente;
                        slot_start     <= 1'b1;
                    end
                end
                BLANK: begin
                    cnt <= cnt + 1'b1;
                    if (cnt == LAST_BLANK) begin
                        estado <= SHOW;
                        blank  <= 1'b0;
                    end
                end
                SHOW: begin
                    if (cnt == LAST_SHOW) begin
                        cnt   <= '0;
                        blank <= 1'b1;
                        if (sel_valido) begin
                            estado         <= BLANK;
                            refrescamiento <= sel_siguiente;
                            slot_start     <= 1'b1;
                        end else begin
                            estado <= IDLE;
                        end
                    end else begin
                        cnt <= cnt + 1'b1;
                    end
                end
                default: begin
                    estado <= IDLE;
                    cnt    <= '0;
                    blank  <= 1'b1;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_escaner_refresco.sv
// Directed bench for escaner_refresco with PRESCALE=8, BLANK_CYCLES=2.
module tb_escaner_refresco;

    localparam int P = 8;
    localparam int B = 2;

    logic       clk;
    logic       rst_n;
    logic       en;
    logic [3:0] digit_mask;
    logic [1:0] refrescamiento;
    logic       blank;
    logic       slot_start;

    int checks;
    int errors;

    escaner_refresco #(.PRESCALE(P), .BLANK_CYCLES(B)) dut (
        .clk            (clk),
        .rst_n          (rst_n),
        .en             (en),
        .digit_mask     (digit_mask),
        .refrescamiento (refrescamiento),
        .blank          (blank),
        .slot_start     (slot_start)
    );

    // 10 ns clock
    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Ghosting watch: the index may only differ from the previous cycle when blank is high
    logic [1:0] prev_idx;
    logic       prev_ok;
    always @(negedge clk) begin
        if (!rst_n) begin
            prev_ok = 1'b0;
        end else begin
            if (prev_ok) begin
                checks++;
                if (refrescamiento !== prev_idx && blank !== 1'b1) begin
                    errors++;
                    $display("[TB] FAIL ghost: index %0d -> %0d while blank=%b", prev_idx, refrescamiento, blank);
                end
            end
            prev_idx = refrescamiento;
            prev_ok  = 1'b1;
        end
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // Reset pulse ending between edges; en/mask are set by the caller afterwards
    task automatic do_reset();
        en         = 1'b0;
        digit_mask = 4'b0000;
        @(posedge clk);
        #1;
        rst_n = 1'b0;
        #3;
        rst_n = 1'b1;
    endtask

    task automatic test_reset();
        rst_n      = 1'b0;
        en         = 1'b0;
        digit_mask = 4'b0000;
        #12;
        checks++;
        if (refrescamiento !== 2'b00) begin
            errors++;
            $display("[TB] FAIL reset_idx: got %0d expected 0", refrescamiento);
        end
        checks++;
        if (blank !== 1'b1) begin
            errors++;
            $display("[TB] FAIL reset_blank: got %b expected 1", blank);
        end
        checks++;
        if (slot_start !== 1'b0) begin
            errors++;
            $display("[TB] FAIL reset_slot_start: got %b expected 0", slot_start);
        end
        rst_n = 1'b1;
    endtask

    task automatic test_full_mask();
        logic [1:0] seq [5] = '{2'd0, 2'd1, 2'd2, 2'd3, 2'd0};
        do_reset();
        en         = 1'b1;
        digit_mask = 4'b1111;
        for (int k = 1; k <= 40; k++) begin
            tick();
            checks++;
            if (refrescamiento !== seq[(k-1)/P]) begin
                errors++;
                $display("[TB] FAIL full_idx k=%0d: got %0d expected %0d", k, refrescamiento, seq[(k-1)/P]);
            end
            checks++;
            if (blank !== (((k-1)%P) < B)) begin
                errors++;
                $display("[TB] FAIL full_blank k=%0d: got %b", k, blank);
            end
            checks++;
            if (slot_start !== (((k-1)%P) == 0)) begin
                errors++;
                $display("[TB] FAIL full_slot_start k=%0d: got %b", k, slot_start);
            end
        end
    endtask

    task automatic test_mask_1010();
        logic [1:0] seq [4] = '{2'd1, 2'd3, 2'd1, 2'd3};
        do_reset();
        en         = 1'b1;
        digit_mask = 4'b1010;
        for (int k = 1; k <= 32; k++) begin
            tick();
            checks++;
            if (refrescamiento !== seq[(k-1)/P]) begin
                errors++;
                $display("[TB] FAIL m1010_idx k=%0d: got %0d expected %0d", k, refrescamiento, seq[(k-1)/P]);
            end
            checks++;
            if (blank !== (((k-1)%P) < B)) begin
                errors++;
                $display("[TB] FAIL m1010_blank k=%0d: got %b", k, blank);
            end
        end
    endtask

    task automatic test_single_digit();
        do_reset();
        en         = 1'b1;
        digit_mask = 4'b0100;
        for (int k = 1; k <= 24; k++) begin
            tick();
            checks++;
            if (refrescamiento !== 2'd2) begin
                errors++;
                $display("[TB] FAIL single_idx k=%0d: got %0d expected 2", k, refrescamiento);
            end
            checks++;
            if (blank !== (((k-1)%P) < B)) begin
                errors++;
                $display("[TB] FAIL single_blank k=%0d: got %b", k, blank);
            end
            checks++;
            if (slot_start !== (((k-1)%P) == 0)) begin
                errors++;
                $display("[TB] FAIL single_slot_start k=%0d: got %b", k, slot_start);
            end
        end
    endtask

    task automatic test_mask_change();
        logic [1:0] exp_idx;
        do_reset();
        en         = 1'b1;
        digit_mask = 4'b1111;
        for (int k = 1; k <= 26; k++) begin
            tick();
            exp_idx = (k <= 8) ? 2'd0 : (k <= 16) ? 2'd1 : 2'd0;
            checks++;
            if (refrescamiento !== exp_idx) begin
                errors++;
                $display("[TB] FAIL change_idx k=%0d: got %0d expected %0d", k, refrescamiento, exp_idx);
            end
            checks++;
            if (blank !== (((k-1)%P) < B)) begin
                errors++;
                $display("[TB] FAIL change_blank k=%0d: got %b", k, blank);
            end
            if (k == 12) digit_mask = 4'b0001;
        end
    endtask

    task automatic test_mask_zero();
        logic [1:0] exp_idx;
        logic       exp_blank;
        logic       exp_ss;
        do_reset();
        en         = 1'b1;
        digit_mask = 4'b0100;
        for (int k = 1; k <= 16; k++) begin
            tick();
            if (k <= 8) begin
                exp_idx   = 2'd2;
                exp_blank = ((k-1)%P) < B;
                exp_ss    = ((k-1)%P) == 0;
            end else if (k <= 12) begin
                exp_idx   = 2'd2;
                exp_blank = 1'b1;
                exp_ss    = 1'b0;
            end else begin
                exp_idx   = 2'd1;
                exp_blank = (k - 13) < B;
                exp_ss    = (k == 13);
            end
            checks++;
            if (refrescamiento !== exp_idx) begin
                errors++;
                $display("[TB] FAIL zero_idx k=%0d: got %0d expected %0d", k, refrescamiento, exp_idx);
            end
            checks++;
            if (blank !== exp_blank) begin
                errors++;
                $display("[TB] FAIL zero_blank k=%0d: got %b expected %b", k, blank, exp_blank);
            end
            checks++;
            if (slot_start !== exp_ss) begin
                errors++;
                $display("[TB] FAIL zero_slot_start k=%0d: got %b expected %b", k, slot_start, exp_ss);
            end
            if (k == 4)  digit_mask = 4'b0000;
            if (k == 12) digit_mask = 4'b0010;
        end
    endtask

    task automatic test_en_low();
        logic [1:0] exp_idx;
        logic       exp_blank;
        logic       exp_ss;
        do_reset();
        en         = 1'b1;
        digit_mask = 4'b1111;
        for (int k = 1; k <= 25; k++) begin
            tick();
            if (k <= 12) begin
                exp_idx   = (k <= 8) ? 2'd0 : 2'd1;
                exp_blank = ((k-1)%P) < B;
                exp_ss    = ((k-1)%P) == 0;
            end else if (k <= 16) begin
                exp_idx   = 2'd1;
                exp_blank = 1'b1;
                exp_ss    = 1'b0;
            end else begin
                exp_idx   = (k <= 24) ? 2'd0 : 2'd1;
                exp_blank = ((k-17)%P) < B;
                exp_ss    = ((k-17)%P) == 0;
            end
            checks++;
            if (refrescamiento !== exp_idx) begin
                errors++;
                $display("[TB] FAIL enlow_idx k=%0d: got %0d expected %0d", k, refrescamiento, exp_idx);
            end
            checks++;
            if (blank !== exp_blank) begin
                errors++;
                $display("[TB] FAIL enlow_blank k=%0d: got %b expected %b", k, blank, exp_blank);
            end
            checks++;
            if (slot_start !== exp_ss) begin
                errors++;
                $display("[TB] FAIL enlow_slot_start k=%0d: got %b expected %b", k, slot_start, exp_ss);
            end
            if (k == 12) en = 1'b0;
            if (k == 16) en = 1'b1;
        end
    endtask

    task automatic test_async_reset();
        logic [1:0] seq [2] = '{2'd0, 2'd1};
        do_reset();
        en         = 1'b1;
        digit_mask = 4'b1111;
        for (int k = 1; k <= 12; k++) tick();
        #2;
        rst_n = 1'b0;
        #1;
        checks++;
        if (refrescamiento !== 2'b00) begin
            errors++;
            $display("[TB] FAIL async_idx: got %0d expected 0", refrescamiento);
        end
        checks++;
        if (blank !== 1'b1) begin
            errors++;
            $display("[TB] FAIL async_blank: got %b expected 1", blank);
        end
        checks++;
        if (slot_start !== 1'b0) begin
            errors++;
            $display("[TB] FAIL async_slot_start: got %b expected 0", slot_start);
        end
        #1;
        rst_n = 1'b1;
        for (int k = 1; k <= 10; k++) begin
            tick();
            checks++;
            if (refrescamiento !== seq[(k-1)/P]) begin
                errors++;
                $display("[TB] FAIL postrst_idx k=%0d: got %0d expected %0d", k, refrescamiento, seq[(k-1)/P]);
            end
            checks++;
            if (blank !== (((k-1)%P) < B)) begin
                errors++;
                $display("[TB] FAIL postrst_blank k=%0d: got %b", k, blank);
            end
        end
    endtask

    // Scenario sequence
    initial begin
        checks   = 0;
        errors   = 0;
        prev_ok  = 1'b0;
        prev_idx = 2'b00;
        test_reset();
        test_full_mask();
        test_mask_1010();
        test_single_digit();
        test_mask_change();
        test_mask_zero();
        test_en_low();
        test_async_reset();
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
